sp_wb_arbiter: RTL and testbench

//  Two-master arbiter for the 8-bit, 24-bit-address Wishbone host bus.
//  M0 is the support processor's byte-serialising bridge; M1 is a second

---
 rtl/sp_arb_pkg.sv | 18 +
 rtl/sp_arb_watchdog.sv | 31 +++
 rtl/sp_wb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_sp_wb_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_arb_pkg.sv
// Shared types and constants for the support-processor Wishbone arbiter.
// FSM encoding, master indices, bus and watchdog widths.
package sp_arb_pkg;

  localparam int ADR_W = 24;
  localparam int DAT_W = 8;
  localparam int WD_W  = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sp_arb_watchdog.sv
// sp_arb_watchdog: next-count and expire pulse for the stalled-slave timer.
// In: i_cnt (current count), i_stb, i_ack, i_clr (no owner). Out: o_cnt_nxt, o_expire.
module sp_arb_watchdog
  import sp_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic [WD_W-1:0] i_cnt,
  input  logic            i_stb,
  input  logic            i_ack,
  input  logic            i_clr,
  output logic [WD_W-1:0] o_cnt_nxt,
  output logic            o_expire
);

  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  // Expire fires on the TIMEOUT-th consecutive unacked strobe cycle.
  always_comb begin
    o_cnt_nxt = '0;
    o_expire  = 1'b0;
    if (~i_clr & i_stb & ~i_ack) begin
      if (i_cnt == LAST) begin
        o_expire = 1'b1;
      end else begin
        o_cnt_nxt = i_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sp_wb_arbiter.sv
// sp_wb_arbiter: two-master arbiter for the 8-bit/24-bit Wishbone host bus.
// Ports: clk, reset_n (async, low); m0_*/m1_* master sides (adr/dat/we/sel/
// stb/cyc in, ack/dat/err out); s_* slave side; grant_o {m1,m0} one-hot owner.
// Optional stalled-slave abort: define SP_ARB_TIMEOUT_EN.
module sp_wb_arbiter
  import sp_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [0:ADR_W-1] m0_adr_i,
  input  logic [0:DAT_W-1] m0_dat_i,
  input  logic             m0_we_i,
  input  logic             m0_sel_i,
  input  logic             m0_stb_i,
  input  logic             m0_cyc_i,
  output logic             m0_ack_o,
  output logic [0:DAT_W-1] m0_dat_o,
  output logic             m0_err_o,
  input  logic [0:ADR_W-1] m1_adr_i,
  input  logic [0:DAT_W-1] m1_dat_i,
  input  logic             m1_we_i,
  input  logic             m1_sel_i,
  input  logic             m1_stb_i,
  input  logic             m1_cyc_i,
  output logic             m1_ack_o,
  output logic [0:DAT_W-1] m1_dat_o,
  output logic             m1_err_o,
  output logic [0:ADR_W-1] s_adr_o,
  output logic [0:DAT_W-1] s_dat_o,
  output logic             s_we_o,
  output logic             s_sel_o,
  output logic             s_stb_o,
  output logic             s_cyc_o,
  input  logic [0:DAT_W-1] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       grant_o
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("sp_wb_arbiter: TIMEOUT must be 1..255");
  end

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_rr;
  logic             w_own0;
  logic             w_own1;
  logic             w_own;
  logic [0:ADR_W-1] w_adr;
  logic [0:DAT_W-1] w_dat;
  logic             w_we;
  logic             w_sel;
  logic             w_stb;
  logic             w_cyc;
  logic             w_tie;
  logic             w_end;
  logic             w_abort;
  logic             w_scyc;
  logic             w_ack;

  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);
  assign w_own  = w_own0 | w_own1;

  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_we  = 1'b0;
    w_sel = 1'b0;
    w_stb = 1'b0;
    w_cyc = 1'b0;
    unique case (1'b1)
      w_own0: begin
        w_adr = m0_adr_i;
        w_dat = m0_dat_i;
        w_we  = m0_we_i;
        w_sel = m0_sel_i;
        w_stb = m0_stb_i;
        w_cyc = m0_cyc_i;
      end
      w_own1: begin
        w_adr = m1_adr_i;
        w_dat = m1_dat_i;
        w_we  = m1_we_i;
        w_sel = m1_sel_i;
        w_stb = m1_stb_i;
        w_cyc = m1_cyc_i;
      end
      default: ;
    endcase
  end

  // r_rr names the master favoured on the next tie.
  assign w_tie = (ROUND_ROBIN != 0) ? r_rr : M0;
  assign w_end = w_own & ~w_cyc;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (m0_cyc_i & m1_cyc_i) begin
          w_state_nxt = (w_tie == M1) ? OWN1 : OWN0;
        end else if (m0_cyc_i) begin
          w_state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (w_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rr    <= M0;
    end else begin
      r_state <= w_state_nxt;
      if (w_end) r_rr <= w_own0 ? M1 : M0;
    end
  end

  // Everything to the slave is gated by the effective cyc so an idle or
  // aborted bus never shows a stale address or strobe.
  assign w_scyc  = w_cyc & ~w_abort;
  assign s_cyc_o = w_scyc;
  assign s_stb_o = w_scyc & w_stb;
  assign s_we_o  = w_scyc & w_we;
  assign s_sel_o = w_scyc & w_sel;
  assign s_adr_o = w_scyc ? w_adr : '0;
  assign s_dat_o = w_scyc ? w_dat : '0;

  assign w_ack    = s_ack_i & s_stb_o;
  assign m0_ack_o = w_ack & w_own0;
  assign m1_ack_o = w_ack & w_own1;
  assign m0_dat_o = w_own0 ? s_dat_i : '0;
  assign m1_dat_o = w_own1 ? s_dat_i : '0;
  assign grant_o  = {w_own1, w_own0};

`ifdef SP_ARB_TIMEOUT_EN
  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_cnt_nxt;
  logic            w_expire;
  logic            r_abort;
  logic            r_err;

  sp_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .i_cnt    (r_wd_cnt),
    .i_stb    (s_stb_o),
    .i_ack    (s_ack_i),
    .i_clr    (~w_own),
    .o_cnt_nxt(w_wd_cnt_nxt),
    .o_expire (w_expire)
  );

  // Abort sticks until the owner lets go of cyc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
      r_abort  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_cnt_nxt;
      r_err    <= w_expire;
      if (~w_cyc) begin
        r_abort <= 1'b0;
      end else if (w_expire) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign w_abort  = r_abort;
  assign m0_err_o = r_err & w_own0;
  assign m1_err_o = r_err & w_own1;
`else
  assign w_abort  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sp_wb_arbiter.sv
// Bench for sp_wb_arbiter: two instances (round-robin, fixed priority)
// share stimulus; table vectors, directed sequences and a random model check.
module tb_sp_wb_arbiter;
  import sp_arb_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [0:23] m0_adr, m1_adr;
  logic [0:7]  m0_dat, m1_dat, s_dat_i;
  logic        m0_we, m0_sel, m0_stb, m0_cyc;
  logic        m1_we, m1_sel, m1_stb, m1_cyc;
  logic        s_ack_i;

  logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
  logic [0:7]  rr_m0_dat, rr_m1_dat, rr_s_dat;
  logic [0:23] rr_s_adr;
  logic        rr_s_we, rr_s_sel, rr_s_stb, rr_s_cyc;
  logic [1:0]  rr_grant;
  logic        fx_m0_ack, fx_m0_err, fx_m1_ack, fx_m1_err;
  logic [0:7]  fx_m0_dat, fx_m1_dat, fx_s_dat;
  logic [0:23] fx_s_adr;
  logic        fx_s_we, fx_s_sel, fx_s_stb, fx_s_cyc;
  logic [1:0]  fx_grant;

  always #5 clk = ~clk;

  sp_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(TMO)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_ack_o(rr_m0_ack), .m0_dat_o(rr_m0_dat), .m0_err_o(rr_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_ack_o(rr_m1_ack), .m1_dat_o(rr_m1_dat), .m1_err_o(rr_m1_err),
    .s_adr_o(rr_s_adr), .s_dat_o(rr_s_dat), .s_we_o(rr_s_we),
    .s_sel_o(rr_s_sel), .s_stb_o(rr_s_stb), .s_cyc_o(rr_s_cyc),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(rr_grant)
  );

  sp_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(TMO)) u_fx (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_ack_o(fx_m0_ack), .m0_dat_o(fx_m0_dat), .m0_err_o(fx_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_ack_o(fx_m1_ack), .m1_dat_o(fx_m1_dat), .m1_err_o(fx_m1_err),
    .s_adr_o(fx_s_adr), .s_dat_o(fx_s_dat), .s_we_o(fx_s_we),
    .s_sel_o(fx_s_sel), .s_stb_o(fx_s_stb), .s_cyc_o(fx_s_cyc),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(fx_grant)
  );

  logic [57:0] rr_vec, fx_vec;
  assign rr_vec = {rr_grant, rr_s_cyc, rr_s_stb, rr_s_we, rr_s_sel,
                   rr_s_adr, rr_s_dat, rr_m0_ack, rr_m0_err, rr_m0_dat,
                   rr_m1_ack, rr_m1_err, rr_m1_dat};
  assign fx_vec = {fx_grant, fx_s_cyc, fx_s_stb, fx_s_we, fx_s_sel,
                   fx_s_adr, fx_s_dat, fx_m0_ack, fx_m0_err, fx_m0_dat,
                   fx_m1_ack, fx_m1_err, fx_m1_dat};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr = '0; m0_dat = '0; m0_we = 0; m0_sel = 0; m0_stb = 0; m0_cyc = 0;
    m1_adr = '0; m1_dat = '0; m1_we = 0; m1_sel = 0; m1_stb = 0; m1_cyc = 0;
    s_dat_i = '0; s_ack_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model: who owns the bus, who is favoured next, abort state.
  typedef struct {
    int owner;
    int fav;
    bit abort;
    int stall;
    bit err;
  } mdl_t;

  mdl_t mr, mf;

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.owner = -1; m.fav = 0; m.abort = 0; m.stall = 0; m.err = 0;
    return m;
  endfunction

  function automatic logic [57:0] mdl_out(mdl_t m);
    logic [0:23] a;
    logic [0:7]  d;
    logic we, sel, stb, cyc, scyc, sstb, ack, o0, o1;
    a = '0; d = '0; we = 0; sel = 0; stb = 0; cyc = 0;
    o0 = (m.owner == 0);
    o1 = (m.owner == 1);
    if (o0) begin a = m0_adr; d = m0_dat; we = m0_we; sel = m0_sel;
                  stb = m0_stb; cyc = m0_cyc; end
    if (o1) begin a = m1_adr; d = m1_dat; we = m1_we; sel = m1_sel;
                  stb = m1_stb; cyc = m1_cyc; end
    scyc = (o0 | o1) & cyc & ~m.abort;
    sstb = scyc & stb;
    ack  = sstb & s_ack_i;
    return {o1, o0, scyc, sstb, scyc & we, scyc & sel,
            scyc ? a : 24'h0, scyc ? d : 8'h0,
            ack & o0, m.err & o0, o0 ? s_dat_i : 8'h0,
            ack & o1, m.err & o1, o1 ? s_dat_i : 8'h0};
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit rr);
    mdl_t n;
    bit   ocyc, ostb;
    n = m;
    n.err = 0;
    ocyc = (m.owner == 0) ? m0_cyc : m1_cyc;
    ostb = (m.owner == 0) ? m0_stb : m1_stb;
    if (m.owner < 0) begin
      if (m0_cyc && m1_cyc) n.owner = rr ? m.fav : 0;
      else if (m0_cyc) n.owner = 0;
      else if (m1_cyc) n.owner = 1;
    end else if (!ocyc) begin
      n.fav = 1 - m.owner;
      n.owner = -1;
      n.abort = 0;
      n.stall = 0;
    end else begin
`ifdef SP_ARB_TIMEOUT_EN
      if (!m.abort && ostb && !s_ack_i) begin
        n.stall = m.stall + 1;
        if (n.stall == TMO) begin
          n.abort = 1;
          n.err = 1;
          n.stall = 0;
        end
      end else begin
        n.stall = 0;
      end
`else
      n.stall = ostb ? 0 : 0;
`endif
    end
    return n;
  endfunction

  typedef struct {
    logic        stb, we;
    logic [23:0] adr;
    logic [7:0]  dat;
    logic        ack;
    logic [7:0]  sdat;
    logic        e_stb, e_we;
    logic [23:0] e_adr;
    logic [7:0]  e_dat;
    logic        e_ack;
    logic [7:0]  e_mdat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, n_ack, ack_pct;
    logic m1_seen, g_bad, fx_m1_won, err_seen, stb_lost;

    tbl[0] = '{0, 0, 24'h123456, 8'h00, 1, 8'hAA,
               0, 0, 24'h123456, 8'h00, 0, 8'hAA};
    tbl[1] = '{1, 1, 24'hABCDEF, 8'h5A, 0, 8'h00,
               1, 1, 24'hABCDEF, 8'h5A, 0, 8'h00};
    tbl[2] = '{1, 1, 24'hABCDEF, 8'h5A, 1, 8'h00,
               1, 1, 24'hABCDEF, 8'h5A, 1, 8'h00};
    tbl[3] = '{1, 0, 24'h000000, 8'h00, 1, 8'hC3,
               1, 0, 24'h000000, 8'h00, 1, 8'hC3};
    tbl[4] = '{1, 0, 24'hFFFFFF, 8'hFF, 0, 8'h3C,
               1, 0, 24'hFFFFFF, 8'hFF, 0, 8'h3C};
    tbl[5] = '{0, 1, 24'h800001, 8'h81, 0, 8'h00,
               0, 1, 24'h800001, 8'h81, 0, 8'h00};

    // Reset state and quiet bus after release.
    idle_inputs();
    reset_n = 1'b0;
    #3;
    chk("reset_rr", 64'(rr_vec), 64'h0);
    chk("reset_fx", 64'(fx_vec), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("quiet", 64'({rr_grant, rr_s_cyc, fx_grant, fx_s_cyc}), 64'h0);
    end

    // Registered grant latency, then table of in-tenure vectors.
    m0_cyc = 1; m0_sel = 1;
    #1;
    chk("lat_pre", 64'({rr_grant, rr_s_cyc}), 64'h0);
    tick();
    chk("lat_post", 64'({rr_grant, rr_s_cyc, rr_s_sel}), 64'b01_1_1);
    for (int i = 0; i < 6; i++) begin
      m0_stb = tbl[i].stb; m0_we = tbl[i].we;
      m0_adr = tbl[i].adr; m0_dat = tbl[i].dat;
      s_ack_i = tbl[i].ack; s_dat_i = tbl[i].sdat;
      #1;
      chk($sformatf("tbl%0d", i),
          64'({rr_s_stb, rr_s_we, rr_s_adr, rr_s_dat,
               rr_m0_ack, rr_m0_dat, rr_m1_ack, rr_m1_dat}),
          64'({tbl[i].e_stb, tbl[i].e_we, tbl[i].e_adr, tbl[i].e_dat,
               tbl[i].e_ack, tbl[i].e_mdat, 1'b0, 8'h00}));
      tick();
    end
    m0_stb = 0; m0_cyc = 0; s_ack_i = 0;
    #1;
    chk("drop_comb", 64'({rr_grant, rr_s_cyc, rr_s_adr}), 64'({2'b01, 1'b0, 24'h0}));
    tick();
    chk("drop_idle", 64'({rr_grant, fx_grant}), 64'h0);

    // Four serialised byte reads, slave acks after two wait cycles.
    m0_cyc = 1; m0_we = 0;
    tick();
    chk("rd_grant", 64'(rr_grant), 64'b01);
    n_ack = 0; m1_seen = 0; g_bad = 0;
    for (int i = 0; i < 4; i++) begin
      m0_stb = 1; m0_adr = 24'h000100 + 24'(i);
      for (int w = 0; w < 2; w++) begin
        #1;
        n_ack += int'(rr_m0_ack);
        m1_seen |= rr_m1_ack;
        g_bad |= (rr_grant != 2'b01);
        tick();
      end
      s_ack_i = 1; s_dat_i = 8'h10 + 8'(i);
      #1;
      chk("rd_byte", 64'({rr_m0_ack, rr_m0_dat}), 64'({1'b1, 8'h10 + 8'(i)}));
      n_ack += int'(rr_m0_ack);
      m1_seen |= rr_m1_ack;
      g_bad |= (rr_grant != 2'b01);
      tick();
      s_ack_i = 0;
    end
    chk("rd_acks", 64'(n_ack), 64'd4);
    chk("rd_m1_quiet", 64'(m1_seen), 64'h0);
    chk("rd_held", 64'(g_bad), 64'h0);
    m0_stb = 0; m0_cyc = 0;
    tick();

    // Simultaneous requests, pointer at M0 after reset.
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("tie_first", 64'({rr_grant, fx_grant}), 64'b01_01);
    tick();
    m0_cyc = 0;
    tick();
    chk("tie_gap", 64'({rr_grant, fx_grant, rr_s_cyc}), 64'h0);
    tick();
    chk("tie_m1", 64'({rr_grant, fx_grant}), 64'b10_10);
    m1_cyc = 0;
    tick();
    m0_cyc = 1;
    tick();
    chk("solo_m0", 64'({rr_grant, fx_grant}), 64'b01_01);
    m0_cyc = 0;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("tie_second", 64'({rr_grant, fx_grant}), 64'b10_01);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    // Fixed priority: M0 returns after every one-cycle release.
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    fx_m1_won = 0;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("starve_own", 64'({fx_grant, rr_grant}),
          64'({2'b01, (r == 0) ? 2'b01 : 2'b10}));
      m0_cyc = 0;
      tick();
      chk("starve_gap", 64'({fx_grant, rr_grant}),
          64'({2'b00, (r == 0) ? 2'b00 : 2'b10}));
      fx_m1_won |= fx_grant[1];
      m0_cyc = 1;
    end
    chk("starve_m1", 64'(fx_m1_won), 64'h0);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    // Spurious ack in idle and with owner strobe low.
    do_reset();
    m1_cyc = 1; s_ack_i = 1; s_dat_i = 8'h77;
    #1;
    chk("spur_idle", 64'({rr_m1_ack, fx_m1_ack, rr_m1_dat}), 64'h0);
    tick();
    chk("spur_nostb", 64'({rr_m1_ack, fx_m1_ack, rr_grant}), 64'b0_0_10);
    m1_stb = 1;
    #1;
    chk("spur_real", 64'({rr_m1_ack, fx_m1_ack, rr_m1_dat}), 64'({2'b11, 8'h77}));

    // Reset mid-tenure clears outputs without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rr", 64'(rr_vec), 64'h0);
    chk("rst_mid_fx", 64'(fx_vec), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();

    // Stalled slave.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1;
    tick();
    chk("to_start", 64'({rr_grant, rr_s_stb}), 64'b01_1);
`ifdef SP_ARB_TIMEOUT_EN
    n = 0;
    while (!rr_m0_err && n < 100) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'(TMO));
    chk("to_abort", 64'({rr_s_stb, rr_s_cyc, rr_m1_err, rr_grant}), 64'b0_0_0_01);
    tick();
    chk("to_pulse", 64'({rr_m0_err, rr_s_cyc, rr_grant}), 64'b0_0_01);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("to_gap", 64'(rr_grant), 64'b00);
    tick();
    chk("to_m1", 64'({rr_grant, rr_s_cyc}), 64'b10_1);
`else
    err_seen = 0; stb_lost = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      err_seen |= rr_m0_err | fx_m0_err;
      stb_lost |= ~rr_s_stb;
    end
    chk("noto_hold", 64'({err_seen, stb_lost, rr_grant}), 64'b0_0_01);
`endif

    // Random stimulus against the reference model.
    do_reset();
    mr = mdl_init();
    mf = mdl_init();
    ack_pct = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) ack_pct = ((i / 500) % 2 == 1) ? 4 : 40;
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 5) == 0) m1_cyc = ~m1_cyc;
      m0_stb = ($urandom_range(0, 99) < 70);
      m1_stb = ($urandom_range(0, 99) < 70);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_sel = 1'($urandom); m1_sel = 1'($urandom);
      m0_adr = 24'($urandom); m1_adr = 24'($urandom);
      m0_dat = 8'($urandom); m1_dat = 8'($urandom);
      s_dat_i = 8'($urandom);
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      #1;
      chk("rand_rr", 64'(rr_vec), 64'(mdl_out(mr)));
      chk("rand_fx", 64'(fx_vec), 64'(mdl_out(mf)));
      @(posedge clk);
      mr = mdl_next(mr, 1'b1);
      mf = mdl_next(mf, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
